systolic_feed_ctrl: RTL

- Sequences reads from ROWS parallel row FIFOs (8-entry, registered data_out, 1-cycle read latency) that feed the left edge of the systolic array.
- Issues a diagonally skewed read schedule: row i starts i cycles after row 0.
- Stalls all rows together whenever any row due to read is empty, so the skew is never broken.
- Reports busy/done per tile to the tile sequencer.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_feed_ctrl_if.sv | 24 ++
 rtl/skew_window.sv | 17 +
 rtl/systolic_feed_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feed controller.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of bits needed to represent value (value itself, not value-1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Tile sequencer / row FIFO side signals of the feed controller.
interface systolic_feed_ctrl_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned KW   = 3
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic [ROWS-1:0] fifo_empty;
  logic [ROWS-1:0] readp;
  logic [ROWS-1:0] valid_out;
  logic            stall;
  logic            busy;
  logic            done;

  modport master (
    output start, k_len, fifo_empty,
    input  readp, valid_out, stall, busy, done
  );

  modport slave (
    input  start, k_len, fifo_empty,
    output readp, valid_out, stall, busy, done
  );
endinterface

// File: rtl/skew_window.sv
// Diagonal skew window: row is due while row <= t < row + k_reg.
module skew_window #(
  parameter int unsigned TW = 4,
  parameter int unsigned KW = 3
) (
  input  logic [TW-1:0] t,
  input  logic [KW-1:0] k_reg,
  input  logic [TW-1:0] row,
  output logic          due
);
  logic [TW-1:0] row_end;

  always_comb begin
    row_end = row + TW'(k_reg);
    due     = (t >= row) && (t < row_end);
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// Skewed read sequencer for the row FIFOs feeding the systolic array left edge.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned K_MAX = 7,
  parameter int unsigned KW    = clogb2(K_MAX),
  parameter int unsigned TW    = clogb2(K_MAX + ROWS - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_feed_ctrl_if.slave  bus
);

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q;
  logic [KW-1:0]   k_q;
  logic [ROWS-1:0] due;
  logic [ROWS-1:0] readp_c;
  logic            stall_c;
  logic            last_step;
  logic [ROWS-1:0] valid_q;
  logic            busy_q;
  logic            done_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    skew_window #(.TW(TW), .KW(KW)) u_win (
      .t     (t_q),
      .k_reg (k_q),
      .row   (TW'(i)),
      .due   (due[i])
    );
  end

  assign last_step = (t_q == (TW'(k_q) + TW'(ROWS - 2)));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (!stall_c && last_step) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Any empty due row freezes every row so the diagonal skew stays intact.
  always_comb begin
    readp_c = '0;
    stall_c = 1'b0;
    if (state_q == S_RUN) begin
      stall_c = |(due & bus.fifo_empty);
      readp_c = stall_c ? '0 : due;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q     <= '0;
      k_q     <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= readp_c;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      if (state_q == S_IDLE && bus.start) begin
        t_q <= '0;
        k_q <= (bus.k_len == '0) ? KW'(1) : bus.k_len;
      end else if (state_q == S_RUN && !stall_c) begin
        t_q <= t_q + TW'(1);
      end
    end
  end

  assign bus.readp     = readp_c;
  assign bus.stall     = stall_c;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
